// File: rtl/wb_matrix_master.sv
// rtl/wb_matrix_master.sv - Wishbone classic burst master driven by a command/data-stream front end
//
// Turns one command (direction, start byte address, word count) into a run of
// single-beat Wishbone classic cycles at consecutive word addresses. Write
// words come in on the wr_* stream and read words leave on the rd_* stream.
//
// Build option: WB_MATRIX_MASTER_TIMEOUT_EN
//   Defined   - each beat may wait at most TIMEOUT cycles for ack. On expiry the
//               burst is abandoned, err is set and done still pulses. err clears
//               on the next accepted command.
//   Undefined - the bus waits for ack indefinitely and err is tied low.
//
// Ports:
//   wb_clk_i, wb_rst_i              clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only while idle)
//   cmd_we, cmd_adr, cmd_len        direction, start byte address, word count
//   wr_data/wr_valid/wr_ready       write-data stream into the master
//   rd_data/rd_valid/rd_ready       read-data stream out of the master
//   wbm_cyc_o, wbm_stb_o, wbm_we_o  Wishbone cycle, strobe, write enable
//   wbm_sel_o                       byte selects (all four lanes during a strobe)
//   wbm_adr_o, wbm_dat_o            Wishbone address and write data
//   wbm_dat_i, wbm_ack_i            Wishbone read data and acknowledge
//   busy                            high whenever the FSM is not idle
//   done                            one-cycle pulse at the end of every command
//   err                             sticky beat-timeout flag

module wb_matrix_master #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [CNT_W-1:0] cmd_len,

    input  logic [31:0]      wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,

    output logic [31:0]      rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,

    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_BUS  = 3'd2;
    localparam logic [2:0] S_PUSH = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic             we_r;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      adr_r;
    logic [31:0]      dat_r;
    logic [31:0]      rd_r;
    logic             in_bus;
    logic             tmo;

    assign in_bus = (state == S_BUS);

`ifdef WB_MATRIX_MASTER_TIMEOUT_EN
    // The timer counts completed no-ack cycles of the current beat, so it never
    // needs to hold more than TIMEOUT-1.
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0] tmr;
    logic             err_r;

    assign tmo = in_bus && !wbm_ack_i && (tmr == TMR_W'(TIMEOUT - 1));
    assign err = err_r;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmr   <= '0;
            err_r <= 1'b0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                err_r <= 1'b0;
            end else if (tmo) begin
                err_r <= 1'b1;
            end

            // Restart the count for every beat, including the next beat of the same burst.
            if (in_bus && !wbm_ack_i && !tmo) begin
                tmr <= tmr + TMR_W'(1);
            end else begin
                tmr <= '0;
            end
        end
    end
`else
    // TIMEOUT only matters when the timeout logic is built in.
    localparam int unused_timeout = TIMEOUT;

    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            we_r  <= 1'b0;
            cnt   <= '0;
            adr_r <= '0;
            dat_r <= '0;
            rd_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        we_r  <= cmd_we;
                        adr_r <= cmd_adr;
                        cnt   <= cmd_len;
                        if (cmd_len == '0) begin
                            state <= S_DONE;
                        end else if (cmd_we) begin
                            state <= S_LOAD;
                        end else begin
                            state <= S_BUS;
                        end
                    end
                end

                S_LOAD: begin
                    if (wr_valid) begin
                        dat_r <= wr_data;
                        state <= S_BUS;
                    end
                end

                S_BUS: begin
                    if (wbm_ack_i) begin
                        // Address arithmetic wraps at 2^32 with no special handling.
                        adr_r <= adr_r + 32'd4;
                        cnt   <= cnt - CNT_W'(1);
                        if (we_r) begin
                            // cnt still holds the pre-decrement count here.
                            state <= (cnt == CNT_W'(1)) ? S_DONE : S_LOAD;
                        end else begin
                            rd_r  <= wbm_dat_i;
                            state <= S_PUSH;
                        end
                    end else if (tmo) begin
                        state <= S_DONE;
                    end
                end

                S_PUSH: begin
                    if (rd_ready) begin
                        state <= (cnt == '0) ? S_DONE : S_BUS;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // All handshake and bus-control outputs decode straight from the state
    // register, so a reset edge clears cyc/stb immediately and no strobe can
    // overlap a transition.
    assign cmd_ready = (state == S_IDLE);
    assign wr_ready  = (state == S_LOAD);
    assign rd_valid  = (state == S_PUSH);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus & we_r;
    assign wbm_sel_o = in_bus ? 4'hF : 4'h0;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign rd_data   = rd_r;

endmodule

// File: tb/tb_wb_matrix_master.sv
// tb/tb_wb_matrix_master.sv - scoreboard bench for wb_matrix_master

module tb_wb_matrix_master;

`ifdef WB_MATRIX_MASTER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        busy;
    logic        done;
    logic        err;

    wb_matrix_master #(
        .CNT_W   (8),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    beat_t       exp_bus[$];
    logic [31:0] exp_rd[$];
    logic [31:0] rd_src[$];
    logic [31:0] wr_q[$];

    int checks     = 0;
    int failures   = 0;
    int ack_budget = 1000;
    int hold_cfg   = 0;
    int hold_left  = 0;
    int done_cnt   = 0;
    int exp_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // Wishbone slave and bus monitor: each acked strobe is one beat and is
    // compared against the next expected beat.
    initial begin
        beat_t b;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        forever begin
            @(negedge wb_clk_i);
            if (wbm_stb_o && ack_budget > 0) begin
                if (exp_bus.size() == 0) begin
                    fail_now("bus_unexpected_beat");
                end else begin
                    b = exp_bus.pop_front();
                    check("bus_adr", wbm_adr_o, b.adr);
                    check("bus_we", {31'b0, wbm_we_o}, {31'b0, b.we});
                    check("bus_sel", {28'b0, wbm_sel_o}, 32'hF);
                    check("bus_cyc", {31'b0, wbm_cyc_o}, 32'h1);
                    if (b.we) check("bus_dat_o", wbm_dat_o, b.dat);
                end
                wbm_dat_i = (rd_src.size() > 0) ? rd_src.pop_front() : 32'hDEAD_BEEF;
                wbm_ack_i = 1'b1;
                ack_budget--;
            end else begin
                wbm_ack_i = 1'b0;
            end
            if (!wbm_stb_o && wbm_sel_o != 4'h0) fail_now("sel_without_stb");
        end
    end

    // Write-data source: a handshake seen at one falling edge is retired at the next.
    initial begin
        logic fire;
        fire     = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 32'h0;
        forever begin
            @(negedge wb_clk_i);
            if (fire && wr_q.size() > 0) void'(wr_q.pop_front());
            wr_valid = (wr_q.size() > 0);
            wr_data  = (wr_q.size() > 0) ? wr_q[0] : 32'h0;
            fire     = wr_valid && wr_ready;
        end
    end

    // Read-data sink and monitor: stalls hold_cfg cycles per word, checking the
    // word is held and no new strobe starts meanwhile.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (rd_valid) begin
                if (exp_rd.size() == 0) begin
                    fail_now("rd_unexpected_word");
                    rd_ready = 1'b1;
                end else if (hold_left > 0) begin
                    check("rd_hold_data", rd_data, exp_rd[0]);
                    check("rd_hold_no_stb", {31'b0, wbm_stb_o}, 32'h0);
                    hold_left--;
                    rd_ready = 1'b0;
                end else begin
                    check("rd_data", rd_data, exp_rd.pop_front());
                    rd_ready  = 1'b1;
                    hold_left = hold_cfg;
                end
            end else begin
                rd_ready = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [7:0] len);
        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_len   = len;
        @(posedge wb_clk_i);
        #1;
        cmd_valid = 1'b0;
        exp_done++;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge wb_clk_i);
        while (!done && n < 300) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (!done) begin
            fail_now({name, "_done_timeout"});
        end else begin
            @(negedge wb_clk_i);
            check({name, "_done_width"}, {31'b0, done}, 32'h0);
            check({name, "_idle_after"}, {31'b0, cmd_ready}, 32'h1);
        end
        check({name, "_bus_left"}, exp_bus.size(), 32'h0);
        check({name, "_rd_left"}, exp_rd.size(), 32'h0);
        check({name, "_wr_left"}, wr_q.size(), 32'h0);
    endtask

    initial begin
        int n;
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_len   = 8'h0;
        repeat (3) @(negedge wb_clk_i);

        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        check("rst_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        check("rst_stb", {31'b0, wbm_stb_o}, 32'h0);
        check("rst_we", {31'b0, wbm_we_o}, 32'h0);
        check("rst_sel", {28'b0, wbm_sel_o}, 32'h0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_dat_o", wbm_dat_o, 32'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        check("rst_wr_ready", {31'b0, wr_ready}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        wb_rst_i = 1'b0;

        // Three-word write burst, zero-wait slave.
        exp_bus.push_back('{32'h3000_0000, 1'b1, 32'h11});
        exp_bus.push_back('{32'h3000_0004, 1'b1, 32'h22});
        exp_bus.push_back('{32'h3000_0008, 1'b1, 32'h33});
        wr_q.push_back(32'h11);
        wr_q.push_back(32'h22);
        wr_q.push_back(32'h33);
        issue(1'b1, 32'h3000_0000, 8'd3);
        check("wr3_busy", {31'b0, busy}, 32'h1);
        wait_done("wr3");

        // Two-word read with a four-cycle stall on every word.
        hold_cfg  = 4;
        hold_left = 4;
        exp_bus.push_back('{32'h3000_0010, 1'b0, 32'h0});
        exp_bus.push_back('{32'h3000_0014, 1'b0, 32'h0});
        rd_src.push_back(32'hA5A5_0001);
        rd_src.push_back(32'hA5A5_0002);
        exp_rd.push_back(32'hA5A5_0001);
        exp_rd.push_back(32'hA5A5_0002);
        issue(1'b0, 32'h3000_0010, 8'd2);
        wait_done("rd2");
        hold_cfg  = 0;
        hold_left = 0;

        // Zero-length command: done on the very next cycle, no bus activity.
        issue(1'b0, 32'h0000_1234, 8'd0);
        @(negedge wb_clk_i);
        check("len0_done", {31'b0, done}, 32'h1);
        check("len0_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        @(negedge wb_clk_i);
        check("len0_done_width", {31'b0, done}, 32'h0);
        check("len0_idle", {31'b0, cmd_ready}, 32'h1);

        // Address wraps past the top of the 32-bit space.
        exp_bus.push_back('{32'hFFFF_FFFC, 1'b1, 32'hCAFE_0001});
        exp_bus.push_back('{32'h0000_0000, 1'b1, 32'hCAFE_0002});
        wr_q.push_back(32'hCAFE_0001);
        wr_q.push_back(32'hCAFE_0002);
        issue(1'b1, 32'hFFFF_FFFC, 8'd2);
        wait_done("wrap");

        // Reset while beat 2 of a four-word read sits in BUS.
        ack_budget = 1;
        exp_bus.push_back('{32'h0000_0100, 1'b0, 32'h0});
        rd_src.push_back(32'hBEEF_0001);
        exp_rd.push_back(32'hBEEF_0001);
        issue(1'b0, 32'h0000_0100, 8'd4);
        exp_done--;
        n = 0;
        @(negedge wb_clk_i);
        while (!(exp_rd.size() == 0 && wbm_stb_o) && n < 100) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 100) fail_now("mid_rst_beat2_timeout");
        check("mid_rst_beat2_adr", wbm_adr_o, 32'h0000_0104);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("mid_rst_cyc", {31'b0, wbm_cyc_o}, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        check("mid_rst_rd_valid", {31'b0, rd_valid}, 32'h0);
        wb_rst_i   = 1'b0;
        ack_budget = 1000;
        rd_src.delete();

        exp_bus.push_back('{32'h0000_0200, 1'b1, 32'h0000_005A});
        wr_q.push_back(32'h0000_005A);
        issue(1'b1, 32'h0000_0200, 8'd1);
        wait_done("post_rst_wr");

`ifdef WB_MATRIX_MASTER_TIMEOUT_EN
        // Silent slave: the strobe must give up after TIMEOUT cycles.
        ack_budget = 0;
        issue(1'b0, 32'h0000_0040, 8'd1);
        n = 0;
        @(negedge wb_clk_i);
        while (wbm_stb_o && n < 50) begin
            n++;
            @(negedge wb_clk_i);
        end
        check("tmo_stb_cycles", n, 32'd8);
        check("tmo_done", {31'b0, done}, 32'h1);
        check("tmo_err", {31'b0, err}, 32'h1);
        @(negedge wb_clk_i);
        check("tmo_err_sticky", {31'b0, err}, 32'h1);
        ack_budget = 1000;
        issue(1'b0, 32'h0, 8'd0);
        check("tmo_err_clear", {31'b0, err}, 32'h0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
`else
        check("err_tied_low", {31'b0, err}, 32'h0);
`endif

        repeat (2) @(negedge wb_clk_i);
        check("done_pulse_count", done_cnt, exp_done);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
